// File: rtl/regfile_dump.sv
// regfile_dump: walks a register-file read port from a latched first index to a
// latched last index (inclusive, wrapping modulo 2**ADDR_W). Each word is
// presented on a valid/ready output channel. done pulses once after the final
// word transfers.
//
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   start      dump request, sampled only while idle
//   abort      cancels any dump in progress (wins over start)
//   first      first register index, latched on start
//   last       last register index (inclusive), latched on start
//   rn         registered read address to the register file
//   q          register-file read data (combinational from rn)
//   out_valid  out_data/out_idx hold a word
//   out_ready  downstream accepts the word
//   out_data   captured register value
//   out_idx    index of the word in out_data
//   busy       high whenever not idle
//   done       one-cycle pulse after the last word transfers
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] rn,
    input  logic [DATA_W-1:0] q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] last_r, last_nx;
    logic [ADDR_W-1:0] rn_nx;
    logic              valid_nx;
    logic [DATA_W-1:0] data_nx;
    logic [ADDR_W-1:0] idx_nx;

    // The latched first index lives in rn itself: it is only ever needed as
    // the starting read address, so no separate register is kept.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= IDLE;
            last_r    <= '0;
            rn        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            state     <= state_nx;
            last_r    <= last_nx;
            rn        <= rn_nx;
            out_valid <= valid_nx;
            out_data  <= data_nx;
            out_idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last_r;
        rn_nx    = rn;
        valid_nx = out_valid;
        data_nx  = out_data;
        idx_nx   = out_idx;
        if (abort) begin
            // A transfer in this same cycle still completes downstream;
            // only the rest of the dump is dropped.
            state_nx = IDLE;
            valid_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        last_nx  = last;
                        rn_nx    = first;
                        state_nx = ADDR;
                    end
                end
                ADDR: begin
                    data_nx  = q;
                    idx_nx   = rn;
                    valid_nx = 1'b1;
                    state_nx = OUT;
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        valid_nx = 1'b0;
                        if (out_idx == last_r) begin
                            state_nx = DONE;
                        end else begin
                            rn_nx    = rn + ADDR_W'(1);
                            state_nx = ADDR;
                        end
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed scenarios with a queue-based model of the
// expected word stream, checked every cycle at the falling edge.
module tb_regfile_dump;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          clrn = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] first = '0;
    logic [AW-1:0] last = '0;
    logic [AW-1:0] rn;
    logic [DW-1:0] q;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_idx;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [0:NR-1];

    regfile_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort),
        .first(first), .last(last), .rn(rn), .q(q),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .done(done)
    );

    assign q = regs[rn];

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model + compare process ----------------
    int      exp_q[$];
    int      log_idx[$];
    int      log_t[$];
    logic [DW-1:0] log_data[$];
    bit      active = 0;
    bit      done_due = 0;
    int      wait_c = 0;
    int      sample = 0;
    int      start_sample = 0;
    int      first_valid = -1;
    int      done_cnt = 0;

    always @(negedge clk) begin
        bit exp_v;
        bit done_next;
        bit was_active;
        sample++;
        if (!clrn) begin
            exp_q.delete();
            active   = 0;
            done_due = 0;
            wait_c   = 0;
        end else begin
            if (wait_c > 0) wait_c--;
            exp_v = active && exp_q.size() > 0 && wait_c == 0 && !done_due;
            chk("out_valid", out_valid, exp_v);
            chk("busy", busy, active);
            chk("done", done, done_due);
            if (done) done_cnt++;
            if (exp_v && out_valid) begin
                chk("out_idx", out_idx, exp_q[0]);
                chk("out_data", out_data, regs[exp_q[0]]);
                if (first_valid < 0) first_valid = sample;
            end
            was_active = active;
            done_next  = 0;
            if (exp_v && out_ready) begin
                log_idx.push_back(exp_q[0]);
                log_data.push_back(out_data);
                log_t.push_back(sample);
                void'(exp_q.pop_front());
                wait_c = 2;
                if (exp_q.size() == 0) done_next = 1;
            end
            if (done_due) active = 0;
            if (abort) begin
                exp_q.delete();
                active    = 0;
                done_next = 0;
                wait_c    = 0;
            end else if (!was_active && start) begin
                int n;
                n = ((int'(last) - int'(first)) % NR + NR) % NR + 1;
                for (int i = 0; i < n; i++) exp_q.push_back((int'(first) + i) % NR);
                active       = 1;
                wait_c       = 2;
                start_sample = sample;
                first_valid  = -1;
            end
            done_due = done_next;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_idx.delete();
        log_data.delete();
        log_t.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input int f, input int l);
        first = AW'(f);
        last  = AW'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        if (busy) chk({nm, "_timeout"}, busy, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) regs[i] = 32'h100 + DW'(i);

        // reset: outputs forced low without any clock edge
        #1 clrn = 1'b0;
        #2;
        chk("rst_rn", rn, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #9 clrn = 1'b1;
        tick();

        // basic dump 3..5
        clear_log();
        out_ready = 1'b1;
        pulse_start(3, 5);
        chk("t1_busy", busy, 1);
        chk("t1_nv", out_valid, 0);
        tick();
        chk("t1_lat_v", out_valid, 1);
        chk("t1_lat_d", out_data, 32'h103);
        wait_idle("t1", 40);
        chk("t1_n", log_idx.size(), 3);
        chk("t1_i0", log_idx[0], 3);
        chk("t1_i1", log_idx[1], 4);
        chk("t1_i2", log_idx[2], 5);
        chk("t1_d0", log_data[0], 32'h103);
        chk("t1_d2", log_data[2], 32'h105);
        chk("t1_lat", first_valid - start_sample, 2);
        chk("t1_gap1", log_t[1] - log_t[0], 2);
        chk("t1_gap2", log_t[2] - log_t[1], 2);
        chk("t1_done", done_cnt, 1);
        tick();

        // wrap 30..1
        clear_log();
        pulse_start(30, 1);
        wait_idle("t2", 40);
        chk("t2_n", log_idx.size(), 4);
        chk("t2_i0", log_idx[0], 30);
        chk("t2_i1", log_idx[1], 31);
        chk("t2_i2", log_idx[2], 0);
        chk("t2_i3", log_idx[3], 1);
        chk("t2_d2", log_data[2], 32'h100);
        chk("t2_done", done_cnt, 1);
        tick();

        // single word 7..7 with a 5-cycle stall
        begin
            int k = 0;
            int stable = 0;
            clear_log();
            out_ready = 1'b0;
            pulse_start(7, 7);
            while (!out_valid && k < 10) begin
                tick();
                k++;
            end
            for (int i = 0; i < 5; i++) begin
                if (out_valid && out_data == 32'h107 && out_idx == 7) stable++;
                tick();
            end
            chk("t3_stall", stable, 5);
            chk("t3_nx", log_idx.size(), 0);
            out_ready = 1'b1;
            wait_idle("t3", 20);
            chk("t3_n", log_idx.size(), 1);
            chk("t3_d", log_data[0], 32'h107);
            chk("t3_done", done_cnt, 1);
            tick();
        end

        // abort at the third word of 0..31, then a fresh dump
        begin
            int k = 0;
            clear_log();
            pulse_start(0, 31);
            while (!(log_idx.size() == 2 && out_valid) && k < 20) begin
                tick();
                k++;
            end
            chk("t4_idx", out_idx, 2);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("t4_valid", out_valid, 0);
            chk("t4_busy", busy, 0);
            chk("t4_n", log_idx.size(), 3);
            repeat (4) tick();
            chk("t4_done", done_cnt, 0);
            chk("t4_n2", log_idx.size(), 3);
            clear_log();
            pulse_start(10, 11);
            wait_idle("t4b", 20);
            chk("t4b_n", log_idx.size(), 2);
            chk("t4b_i1", log_idx[1], 11);
            chk("t4b_done", done_cnt, 1);
            tick();
        end

        // start while busy ignored; abort+start in idle ignored
        clear_log();
        pulse_start(3, 5);
        tick();
        tick();
        pulse_start(20, 25);
        wait_idle("t5", 40);
        chk("t5_n", log_idx.size(), 3);
        chk("t5_i2", log_idx[2], 5);
        chk("t5_done", done_cnt, 1);
        tick();
        clear_log();
        abort = 1'b1;
        pulse_start(8, 9);
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        repeat (4) tick();
        chk("t5_n2", log_idx.size(), 0);
        chk("t5_done2", done_cnt, 0);

        // reset mid-dump
        begin
            int k = 0;
            clear_log();
            pulse_start(0, 31);
            while (log_idx.size() < 3 && k < 20) begin
                tick();
                k++;
            end
            #1 clrn = 1'b0;
            #1;
            chk("t6_rn", rn, 0);
            chk("t6_valid", out_valid, 0);
            chk("t6_data", out_data, 0);
            chk("t6_idx", out_idx, 0);
            chk("t6_busy", busy, 0);
            chk("t6_done", done, 0);
            @(posedge clk);
            #2 clrn = 1'b1;
            clear_log();
            repeat (5) tick();
            chk("t6_busy2", busy, 0);
            chk("t6_nd", done_cnt, 0);
            chk("t6_nw", log_idx.size(), 0);
            pulse_start(4, 4);
            wait_idle("t6b", 20);
            chk("t6b_n", log_idx.size(), 1);
            chk("t6b_d", log_data[0], 32'h104);
            chk("t6b_done", done_cnt, 1);
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
